// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared ID/EX types: ALUOp encoding, control bundle and bubble.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   typedef enum logic [1:0] {
      ALU_LS = 2'b00,
      ALU_BR = 2'b01,
      ALU_RI = 2'b10,
      ALU_JL = 2'b11
   } alu_op_t;

   // Field order matches the id_ctrl bus, MSB first.
   typedef struct packed {
      logic alusrc;
      logic memread;
      logic memwrite;
      logic regwrite;
      logic memtoreg;
      logic branch;
      logic jump;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detection between EX and ID.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
   import pipe_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic            ex_valid,
   input  logic            ex_memread,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            id_valid,
   input  logic            id_use_rs1,
   input  logic [RA_W-1:0] id_rs1,
   input  logic            id_use_rs2,
   input  logic [RA_W-1:0] id_rs2,
   output logic            load_use
);

   logic w_rd_nonzero;
   logic w_hit_rs1;
   logic w_hit_rs2;

   // x0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign w_rd_nonzero = (ex_rd != '0);
   assign w_hit_rs1    = id_use_rs1 & (id_rs1 == ex_rd);
   assign w_hit_rs2    = id_use_rs2 & (id_rs2 == ex_rd);

   assign load_use = ex_valid & ex_memread & w_rd_nonzero & id_valid
                   & (w_hit_rs1 | w_hit_rs2);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use stall, flush, hold and
//               saturating bubble/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rd1,
   input  logic [XLEN-1:0]  id_rd2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [1:0]       id_aluop,
   input  logic [6:0]       id_funct7,
   input  logic [2:0]       id_funct3,
   input  logic [6:0]       id_ctrl,
   input  logic             hold,
   input  logic             flush,
   output logic             stall,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rd1,
   output logic [XLEN-1:0]  ex_rd2,
   output logic [XLEN-1:0]  ex_imm,
   output logic [RA_W-1:0]  ex_rs1,
   output logic [RA_W-1:0]  ex_rs2,
   output logic [RA_W-1:0]  ex_rd,
   output logic [1:0]       ex_aluop,
   output logic [6:0]       ex_funct7,
   output logic [2:0]       ex_funct3,
   output logic [6:0]       ex_ctrl,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             r_valid;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_rd1;
   logic [XLEN-1:0]  r_rd2;
   logic [XLEN-1:0]  r_imm;
   logic [RA_W-1:0]  r_rs1;
   logic [RA_W-1:0]  r_rs2;
   logic [RA_W-1:0]  r_rd;
   alu_op_t          r_aluop;
   logic [6:0]       r_funct7;
   logic [2:0]       r_funct3;
   ctrl_t            r_ctrl;
   logic [CNT_W-1:0] r_bubble_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_load_use;
   logic             w_bubble;

   load_use_detect #(
      .RA_W (RA_W)
   ) u_load_use_detect (
      .ex_valid   (r_valid),
      .ex_memread (r_ctrl.memread),
      .ex_rd      (r_rd),
      .id_valid   (id_valid),
      .id_use_rs1 (id_use_rs1),
      .id_rs1     (id_rs1),
      .id_use_rs2 (id_use_rs2),
      .id_rs2     (id_rs2),
      .load_use   (w_load_use)
   );

   // A flush already kills the ID instruction, and a hold freezes everything,
   // so neither case needs the front end to re-present it.
   assign stall    = w_load_use & ~flush & ~hold;
   assign w_bubble = flush | w_load_use;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid      <= 1'b0;
         r_pc         <= '0;
         r_rd1        <= '0;
         r_rd2        <= '0;
         r_imm        <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_rd         <= '0;
         r_aluop      <= ALU_LS;
         r_funct7     <= '0;
         r_funct3     <= '0;
         r_ctrl       <= CTRL_NOP;
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else if (!hold) begin
         if (w_bubble) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_imm    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_aluop  <= ALU_LS;
            r_funct7 <= '0;
            r_funct3 <= '0;
            r_ctrl   <= CTRL_NOP;
            if (flush) begin
               if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
               if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
         end else begin
            r_valid  <= id_valid;
            r_pc     <= id_pc;
            r_rd1    <= id_rd1;
            r_rd2    <= id_rd2;
            r_imm    <= id_imm;
            r_rs1    <= id_rs1;
            r_rs2    <= id_rs2;
            r_rd     <= id_rd;
            r_aluop  <= alu_op_t'(id_aluop);
            r_funct7 <= id_funct7;
            r_funct3 <= id_funct3;
            r_ctrl   <= id_valid ? ctrl_t'(id_ctrl) : CTRL_NOP;
         end
      end
   end

   assign ex_valid   = r_valid;
   assign ex_pc      = r_pc;
   assign ex_rd1     = r_rd1;
   assign ex_rd2     = r_rd2;
   assign ex_imm     = r_imm;
   assign ex_rs1     = r_rs1;
   assign ex_rs2     = r_rs2;
   assign ex_rd      = r_rd;
   assign ex_aluop   = r_aluop;
   assign ex_funct7  = r_funct7;
   assign ex_funct3  = r_funct3;
   assign ex_ctrl    = r_ctrl;
   assign bubble_cnt = r_bubble_cnt;
   assign flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

   localparam logic [6:0] C_CTRL_LW   = 7'b1101100;
   localparam logic [6:0] C_CTRL_ADD  = 7'b0001000;
   localparam logic [6:0] C_CTRL_ADDI = 7'b1001000;

   logic        clk, reset, id_valid, id_use_rs1, id_use_rs2, hold, flush;
   logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [1:0]  id_aluop;
   logic [6:0]  id_funct7, id_ctrl;
   logic [2:0]  id_funct3;

   logic        stall, ex_valid;
   logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [1:0]  ex_aluop;
   logic [6:0]  ex_funct7, ex_ctrl;
   logic [2:0]  ex_funct3;
   logic [15:0] bubble_cnt, flush_cnt;

   logic        d4_stall, d4_ex_valid;
   logic [31:0] d4_ex_pc, d4_ex_rd1, d4_ex_rd2, d4_ex_imm;
   logic [4:0]  d4_ex_rs1, d4_ex_rs2, d4_ex_rd;
   logic [1:0]  d4_ex_aluop;
   logic [6:0]  d4_ex_funct7, d4_ex_ctrl;
   logic [2:0]  d4_ex_funct3;
   logic [3:0]  d4_bubble_cnt, d4_flush_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .id_aluop(id_aluop), .id_funct7(id_funct7),
      .id_funct3(id_funct3), .id_ctrl(id_ctrl), .hold(hold), .flush(flush),
      .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
      .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_aluop(ex_aluop), .ex_funct7(ex_funct7),
      .ex_funct3(ex_funct3), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt),
      .flush_cnt(flush_cnt)
   );

   id_ex_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .id_aluop(id_aluop), .id_funct7(id_funct7),
      .id_funct3(id_funct3), .id_ctrl(id_ctrl), .hold(hold), .flush(flush),
      .stall(d4_stall), .ex_valid(d4_ex_valid), .ex_pc(d4_ex_pc),
      .ex_rd1(d4_ex_rd1), .ex_rd2(d4_ex_rd2), .ex_imm(d4_ex_imm),
      .ex_rs1(d4_ex_rs1), .ex_rs2(d4_ex_rs2), .ex_rd(d4_ex_rd),
      .ex_aluop(d4_ex_aluop), .ex_funct7(d4_ex_funct7),
      .ex_funct3(d4_ex_funct3), .ex_ctrl(d4_ex_ctrl),
      .bubble_cnt(d4_bubble_cnt), .flush_cnt(d4_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic [1:0] op,
                         input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] ctl);
      id_valid = v; id_pc = pc; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
      id_aluop = op; id_funct7 = f7; id_funct3 = f3; id_ctrl = ctl;
   endtask

   task automatic set_lw_x6();
      set_id(1'b1, 32'h200, 32'h1000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd6,
             1'b1, 1'b0, 2'b00, 7'd0, 3'b010, C_CTRL_LW);
   endtask

   task automatic set_add_x7_x6_x1();
      set_id(1'b1, 32'h204, 32'hAAAA, 32'h1111, 32'h0, 5'd6, 5'd1, 5'd7,
             1'b1, 1'b1, 2'b10, 7'd0, 3'b000, C_CTRL_ADD);
   endtask

   task automatic do_reset();
      hold = 1'b0; flush = 1'b0; reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      set_id(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
             5'($urandom), 1'b1, 1'b1, 2'($urandom), 7'($urandom), 3'($urandom), 7'($urandom));
      hold = 1'($urandom); flush = 1'($urandom); reset = 1'b0;
      step(); step();
      total_cnt++;
      if ({ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm} !== '0)
         $display("FAIL reset_data: got v=%b pc=%h rd1=%h rd2=%h imm=%h, want all 0",
                  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm);
      else pass_cnt++;
      total_cnt++;
      if ({ex_rs1, ex_rs2, ex_rd, ex_aluop, ex_funct7, ex_funct3, ex_ctrl} !== '0)
         $display("FAIL reset_ctrl: got rs1=%h rs2=%h rd=%h op=%b f7=%h f3=%h ctl=%b, want all 0",
                  ex_rs1, ex_rs2, ex_rd, ex_aluop, ex_funct7, ex_funct3, ex_ctrl);
      else pass_cnt++;
      total_cnt++;
      if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall !== 1'b0)
         $display("FAIL reset_cnt: got bubble=%0d flush=%0d stall=%b, want 0 0 0",
                  bubble_cnt, flush_cnt, stall);
      else pass_cnt++;
      reset = 1'b1; hold = 1'b0; flush = 1'b0;
   endtask

   task automatic test_pass_through();
      // ADDI x5, x0, 7
      set_id(1'b1, 32'h100, 32'h0, 32'h55, 32'd7, 5'd0, 5'd7, 5'd5,
             1'b1, 1'b0, 2'b10, 7'd0, 3'b000, C_CTRL_ADDI);
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL pass_stall: got %b want 0", stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (ex_valid !== 1'b1 || ex_aluop !== 2'b10 || ex_imm !== 32'd7 || ex_rd !== 5'd5)
         $display("FAIL pass_core: got v=%b op=%b imm=%h rd=%0d, want 1 10 7 5",
                  ex_valid, ex_aluop, ex_imm, ex_rd);
      else pass_cnt++;
      total_cnt++;
      if (ex_pc !== 32'h100 || ex_rd2 !== 32'h55 || ex_ctrl !== C_CTRL_ADDI || ex_funct3 !== 3'b000)
         $display("FAIL pass_fields: got pc=%h rd2=%h ctl=%b f3=%b, want 100 55 1001000 000",
                  ex_pc, ex_rd2, ex_ctrl, ex_funct3);
      else pass_cnt++;
      // invalid slot: fields pass, control is squashed
      set_id(1'b0, 32'h104, 32'h1, 32'h2, 32'h3, 5'd3, 5'd4, 5'd9,
             1'b0, 1'b0, 2'b01, 7'h20, 3'b101, C_CTRL_LW);
      step();
      total_cnt++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || ex_rd !== 5'd9 || ex_imm !== 32'h3
          || ex_funct7 !== 7'h20 || ex_aluop !== 2'b01)
         $display("FAIL invalid_slot: got v=%b ctl=%b rd=%0d imm=%h f7=%h op=%b, want 0 0 9 3 20 01",
                  ex_valid, ex_ctrl, ex_rd, ex_imm, ex_funct7, ex_aluop);
      else pass_cnt++;
   endtask

   task automatic test_load_use();
      set_lw_x6();
      step();
      set_add_x7_x6_x1();
      #1;
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || ex_rd !== 5'd0 || ex_rd1 !== 32'd0
          || bubble_cnt !== 16'd1 || stall !== 1'b0)
         $display("FAIL lu_bubble: got v=%b ctl=%b rd=%0d rd1=%h bub=%0d stall=%b, want 0 0 0 0 1 0",
                  ex_valid, ex_ctrl, ex_rd, ex_rd1, bubble_cnt, stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_rs1 !== 5'd6 || ex_ctrl !== C_CTRL_ADD
          || ex_rd1 !== 32'hAAAA || bubble_cnt !== 16'd1 || flush_cnt !== 16'd0)
         $display("FAIL lu_resume: got v=%b rd=%0d rs1=%0d ctl=%b rd1=%h bub=%0d fl=%0d, want 1 7 6 0001000 aaaa 1 0",
                  ex_valid, ex_rd, ex_rs1, ex_ctrl, ex_rd1, bubble_cnt, flush_cnt);
      else pass_cnt++;
   endtask

   task automatic test_x0_load();
      set_id(1'b1, 32'h300, 32'h0, 32'h0, 32'h8, 5'd2, 5'd0, 5'd0,
             1'b1, 1'b0, 2'b00, 7'd0, 3'b010, C_CTRL_LW);
      step();
      set_id(1'b1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8,
             1'b1, 1'b1, 2'b10, 7'd0, 3'b000, C_CTRL_ADD);
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL x0_stall: got %b want 0", stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || bubble_cnt !== 16'd1)
         $display("FAIL x0_flow: got v=%b rd=%0d bub=%0d, want 1 8 1", ex_valid, ex_rd, bubble_cnt);
      else pass_cnt++;
   endtask

   task automatic test_flush_vs_load_use();
      do_reset();
      set_lw_x6();
      step();
      set_add_x7_x6_x1();
      flush = 1'b1;
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL fl_lu_stall: got %b want 0", stall);
      else pass_cnt++;
      step();
      flush = 1'b0;
      total_cnt++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || ex_pc !== 32'd0
          || flush_cnt !== 16'd1 || bubble_cnt !== 16'd0)
         $display("FAIL fl_lu_state: got v=%b ctl=%b pc=%h fl=%0d bub=%0d, want 0 0 0 1 0",
                  ex_valid, ex_ctrl, ex_pc, flush_cnt, bubble_cnt);
      else pass_cnt++;
   endtask

   task automatic test_hold();
      do_reset();
      set_lw_x6();
      step();
      set_add_x7_x6_x1();
      hold = 1'b1; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (stall !== 1'b0) $display("FAIL hold_stall[%0d]: got %b want 0", i, stall);
         else pass_cnt++;
         step();
         total_cnt++;
         if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_ctrl !== C_CTRL_LW || ex_pc !== 32'h200
             || flush_cnt !== 16'd0 || bubble_cnt !== 16'd0)
            $display("FAIL hold_frozen[%0d]: got v=%b rd=%0d ctl=%b pc=%h fl=%0d bub=%0d, want 1 6 1101100 200 0 0",
                     i, ex_valid, ex_rd, ex_ctrl, ex_pc, flush_cnt, bubble_cnt);
         else pass_cnt++;
      end
      hold = 1'b0; flush = 1'b0;
      #1;
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL hold_release_stall: got %b want 1", stall);
      else pass_cnt++;
      step();
      total_cnt++;
      if (ex_valid !== 1'b0 || bubble_cnt !== 16'd1 || flush_cnt !== 16'd0)
         $display("FAIL hold_release_bubble: got v=%b bub=%0d fl=%0d, want 0 1 0",
                  ex_valid, bubble_cnt, flush_cnt);
      else pass_cnt++;
      step();
      total_cnt++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd7)
         $display("FAIL hold_release_add: got v=%b rd=%0d, want 1 7", ex_valid, ex_rd);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall();
      set_lw_x6();
      step();
      set_add_x7_x6_x1();
      reset = 1'b0;
      step();
      total_cnt++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || stall !== 1'b0 || bubble_cnt !== 16'd0)
         $display("FAIL reset_mid_stall: got v=%b ctl=%b stall=%b bub=%0d, want 0 0 0 0",
                  ex_valid, ex_ctrl, stall, bubble_cnt);
      else pass_cnt++;
      reset = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      flush = 1'b1;
      for (int i = 0; i < 20; i++) step();
      flush = 1'b0;
      total_cnt++;
      if (d4_flush_cnt !== 4'd15 || d4_bubble_cnt !== 4'd0)
         $display("FAIL sat_cnt4: got fl=%0d bub=%0d, want 15 0", d4_flush_cnt, d4_bubble_cnt);
      else pass_cnt++;
      total_cnt++;
      if (flush_cnt !== 16'd20) $display("FAIL sat_cnt16: got fl=%0d want 20", flush_cnt);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b0; hold = 1'b0; flush = 1'b0;
      set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 2'b00, '0, '0, '0);
      test_reset();
      test_pass_through();
      test_load_use();
      test_x0_load();
      test_flush_vs_load_use();
      test_hold();
      test_reset_mid_stall();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
